alu_ctrl_pipe: RTL and testbench

- Registered, parametrised ALU control stage between decode (ID) and execute (EX).
- Decodes the 6-bit opcode and 6-bit funct into an extended ALU control code.
- Holds the result in an ID/EX control register with a valid/ready handshake.
- Sequences multi-cycle MULT/DIV operations by holding off new instructions until the configured latency elapses.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/alu_decode.sv | 67 ++++++
 rtl/alu_ctrl_pipe.sv | 108 ++++++++++
 tb/tb_alu_ctrl_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Purpose : shared MIPS decode constants, ALU control codes and pipe FSM states.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mips_pkg;

  // Opcodes
  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] Jop     = 6'd2;
  localparam logic [5:0] JALop   = 6'd3;
  localparam logic [5:0] BEQ     = 6'd4;
  localparam logic [5:0] BNE     = 6'd5;
  localparam logic [5:0] ADD_IMM = 6'd8;
  localparam logic [5:0] ADDIU   = 6'd9;
  localparam logic [5:0] SLTI    = 6'd10;
  localparam logic [5:0] SLTIU   = 6'd11;
  localparam logic [5:0] ANDI    = 6'd12;
  localparam logic [5:0] ORI     = 6'd13;
  localparam logic [5:0] XORI    = 6'd14;
  localparam logic [5:0] LUI     = 6'd15;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  // Funct codes (op 0)
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // ALU control codes (base 4-bit encoding, zero-extended to CTRL_W)
  localparam logic [3:0] ALU_ERR  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_MULT = 4'd12;
  localparam logic [3:0] ALU_DIV  = 4'd13;
  localparam logic [3:0] ALU_LUI  = 4'd14;
  localparam logic [3:0] ALU_RSVD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MD   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Purpose : combinational op/funct -> ALU control decode.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; the caller decides when to sample.
// Ports: op, funct in; ctrl (CTRL_W), illegal, use_imm, is_muldiv out.
module alu_decode
  import mips_pkg::*;
#(
  parameter int CTRL_W        = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              use_imm,
  output logic              is_muldiv
);

  logic [3:0] code;

  always_comb begin
    code      = ALU_ERR;
    illegal   = 1'b0;
    use_imm   = 1'b0;
    is_muldiv = 1'b0;
    case (op)
      ALUop: begin
        case (funct)
          F_ADD, F_ADDU: code = ALU_ADD;
          F_SUB, F_SUBU: code = ALU_SUB;
          F_AND:         code = ALU_AND;
          F_OR:          code = ALU_OR;
          F_XOR:         code = ALU_XOR;
          F_NOR:         code = ALU_NOR;
          F_SLT:         code = ALU_SLT;
          F_SLTU:        code = ALU_SLTU;
          F_SLL:         code = ALU_SLL;
          F_SRL:         code = ALU_SRL;
          F_SRA:         code = ALU_SRA;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            // Without the multiplier/divider these are just unknown functs.
            if (ENABLE_MULDIV != 0) begin
              code      = (funct[1]) ? ALU_DIV : ALU_MULT;
              is_muldiv = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          default:       illegal = 1'b1;
        endcase
      end
      LW, SW, ADD_IMM, ADDIU: begin code = ALU_ADD;  use_imm = 1'b1; end
      Jop, JALop:                   code = ALU_ADD;
      BEQ, BNE:                     code = ALU_SUB;
      SLTI:                   begin code = ALU_SLT;  use_imm = 1'b1; end
      SLTIU:                  begin code = ALU_SLTU; use_imm = 1'b1; end
      ANDI:                   begin code = ALU_AND;  use_imm = 1'b1; end
      ORI:                    begin code = ALU_OR;   use_imm = 1'b1; end
      XORI:                   begin code = ALU_XOR;  use_imm = 1'b1; end
      LUI:                    begin code = ALU_LUI;  use_imm = 1'b1; end
      default:                      illegal = 1'b1;
    endcase
  end

  assign ctrl = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Purpose : ID/EX ALU control register with MULT/DIV occupancy sequencing.
// Latency : 1 cycle capture-to-output; MULT/DIV results appear after MULDIV_CYCLES busy cycles.
// Backpressure : id_ready drops while EX holds unconsumed content (ex_ready=0) or MULT/DIV is busy.
// Ports: clk, rst_n, flush; id_valid/id_op/id_funct/id_ready (ID side);
//        ex_ready/ex_valid/ex_alu_ctrl/ex_illegal/ex_use_imm/ex_busy/ex_md_done (EX side).
module alu_ctrl_pipe
  import mips_pkg::*;
#(
  parameter int CTRL_W        = 4,
  parameter int MULDIV_CYCLES = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  output logic              id_ready,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic              ex_illegal,
  output logic              ex_use_imm,
  output logic              ex_busy,
  output logic              ex_md_done
);

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               md_done_q, md_done_nxt;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_illegal, dec_use_imm, dec_muldiv;
  logic               capture;

  alu_decode #(
    .CTRL_W        (CTRL_W),
    .ENABLE_MULDIV (ENABLE_MULDIV)
  ) u_dec (
    .op        (id_op),
    .funct     (id_funct),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal),
    .use_imm   (dec_use_imm),
    .is_muldiv (dec_muldiv)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign id_ready = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & ex_ready));
  assign capture  = id_valid & id_ready & ~flush;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    md_done_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (capture) begin
          state_nxt = dec_muldiv ? ST_MD : ST_HOLD;
          cnt_nxt   = dec_muldiv ? MD_LOAD : 8'd0;
        end else if (state == ST_HOLD && ex_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MD: begin
        if (cnt == 8'd0) begin
          state_nxt   = ST_HOLD;
          md_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = 8'd0;
      md_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      md_done_q   <= 1'b0;
      ex_alu_ctrl <= '0;
      ex_illegal  <= 1'b0;
      ex_use_imm  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      md_done_q <= md_done_nxt;
      if (capture) begin
        ex_alu_ctrl <= dec_ctrl;
        ex_illegal  <= dec_illegal;
        ex_use_imm  <= dec_use_imm;
      end
    end
  end

  assign ex_valid   = (state == ST_HOLD);
  assign ex_busy    = (state == ST_MD);
  assign ex_md_done = md_done_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n, flush, id_valid, ex_ready;
  logic [5:0] id_op, id_funct;

  always #5 clk = ~clk;

  // Three configurations share the same input stream.
  // 0: CTRL_W=4 MULDIV_CYCLES=4 ENABLE_MULDIV=1
  // 1: CTRL_W=6 MULDIV_CYCLES=1 ENABLE_MULDIV=1
  // 2: CTRL_W=4 MULDIV_CYCLES=3 ENABLE_MULDIV=0
  logic       rdy0, vld0, ill0, imm0, bsy0, dn0;
  logic       rdy1, vld1, ill1, imm1, bsy1, dn1;
  logic       rdy2, vld2, ill2, imm2, bsy2, dn2;
  logic [3:0] ctrl0, ctrl2;
  logic [5:0] ctrl1;

  alu_ctrl_pipe #(.CTRL_W(4), .MULDIV_CYCLES(4), .ENABLE_MULDIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_op(id_op),
    .id_funct(id_funct), .id_ready(rdy0), .ex_ready(ex_ready), .ex_valid(vld0),
    .ex_alu_ctrl(ctrl0), .ex_illegal(ill0), .ex_use_imm(imm0), .ex_busy(bsy0),
    .ex_md_done(dn0));

  alu_ctrl_pipe #(.CTRL_W(6), .MULDIV_CYCLES(1), .ENABLE_MULDIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_op(id_op),
    .id_funct(id_funct), .id_ready(rdy1), .ex_ready(ex_ready), .ex_valid(vld1),
    .ex_alu_ctrl(ctrl1), .ex_illegal(ill1), .ex_use_imm(imm1), .ex_busy(bsy1),
    .ex_md_done(dn1));

  alu_ctrl_pipe #(.CTRL_W(4), .MULDIV_CYCLES(3), .ENABLE_MULDIV(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_op(id_op),
    .id_funct(id_funct), .id_ready(rdy2), .ex_ready(ex_ready), .ex_valid(vld2),
    .ex_alu_ctrl(ctrl2), .ex_illegal(ill2), .ex_use_imm(imm2), .ex_busy(bsy2),
    .ex_md_done(dn2));

  logic       o_rdy [3], o_vld [3], o_ill [3], o_imm [3], o_bsy [3], o_dn [3];
  logic [5:0] o_ctrl [3];

  assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy2;
  assign o_vld[0] = vld0; assign o_vld[1] = vld1; assign o_vld[2] = vld2;
  assign o_ill[0] = ill0; assign o_ill[1] = ill1; assign o_ill[2] = ill2;
  assign o_imm[0] = imm0; assign o_imm[1] = imm1; assign o_imm[2] = imm2;
  assign o_bsy[0] = bsy0; assign o_bsy[1] = bsy1; assign o_bsy[2] = bsy2;
  assign o_dn[0]  = dn0;  assign o_dn[1]  = dn1;  assign o_dn[2]  = dn2;
  assign o_ctrl[0] = {2'b00, ctrl0};
  assign o_ctrl[1] = ctrl1;
  assign o_ctrl[2] = {2'b00, ctrl2};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int md_n  [3] = '{4, 1, 3};
  bit md_en [3] = '{1'b1, 1'b1, 1'b0};

  // Decode tables straight from the control-code list; -1 marks illegal.
  int op_tab  [64];
  bit imm_tab [64];
  int fn_tab  [64];

  bit m_vld [3], m_ill [3], m_imm [3], m_dn [3];
  int m_left [3], m_ctrl [3];

  function automatic void init_tables();
    for (int k = 0; k < 64; k++) begin op_tab[k] = -1; imm_tab[k] = 0; fn_tab[k] = -1; end
    op_tab[35] = 1;  op_tab[43] = 1;  op_tab[8] = 1;  op_tab[9] = 1;
    op_tab[2]  = 1;  op_tab[3]  = 1;  op_tab[4] = 2;  op_tab[5] = 2;
    op_tab[10] = 5;  op_tab[11] = 8;  op_tab[12] = 3; op_tab[13] = 4;
    op_tab[14] = 6;  op_tab[15] = 14;
    imm_tab[35] = 1; imm_tab[43] = 1; imm_tab[8] = 1;  imm_tab[9] = 1;  imm_tab[10] = 1;
    imm_tab[11] = 1; imm_tab[12] = 1; imm_tab[13] = 1; imm_tab[14] = 1; imm_tab[15] = 1;
    fn_tab[32] = 1;  fn_tab[33] = 1;  fn_tab[34] = 2;  fn_tab[35] = 2;
    fn_tab[36] = 3;  fn_tab[37] = 4;  fn_tab[38] = 6;  fn_tab[39] = 7;
    fn_tab[42] = 5;  fn_tab[43] = 8;  fn_tab[0]  = 9;  fn_tab[2]  = 10;
    fn_tab[3]  = 11; fn_tab[24] = 12; fn_tab[25] = 12; fn_tab[26] = 13; fn_tab[27] = 13;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 0; m_ill[i] = 0; m_imm[i] = 0; m_dn[i] = 0; m_left[i] = 0; m_ctrl[i] = 0;
    end
  endfunction

  function automatic bit model_ready(input int i, input logic er);
    return (m_left[i] == 0) && (!m_vld[i] || er);
  endfunction

  function automatic void model_step(input int i, input bit cap, input logic er,
                                     input logic fl, input logic [5:0] op, input logic [5:0] fn);
    int c; bit imm, md;
    if (fl) begin
      m_vld[i] = 0; m_left[i] = 0; m_dn[i] = 0;
      return;
    end
    m_dn[i] = 0;
    if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin m_vld[i] = 1; m_dn[i] = 1; end
    end else if (cap) begin
      if (op == 0) begin c = fn_tab[fn]; imm = 0; end
      else         begin c = op_tab[op]; imm = imm_tab[op]; end
      md = (c == 12 || c == 13);
      if (md && !md_en[i]) begin c = -1; md = 0; end
      if (c < 0) begin m_ctrl[i] = 0; m_ill[i] = 1; m_imm[i] = 0; end
      else       begin m_ctrl[i] = c; m_ill[i] = 0; m_imm[i] = imm; end
      if (md) begin m_left[i] = md_n[i]; m_vld[i] = 0; end
      else    m_vld[i] = 1;
    end else if (m_vld[i] && er) begin
      m_vld[i] = 0;
    end
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ex_valid[%0d]", i),    32'(o_vld[i]),  32'(m_vld[i]));
      chk($sformatf("ex_busy[%0d]", i),     32'(o_bsy[i]),  32'(m_left[i] > 0));
      chk($sformatf("ex_md_done[%0d]", i),  32'(o_dn[i]),   32'(m_dn[i]));
      chk($sformatf("ex_alu_ctrl[%0d]", i), 32'(o_ctrl[i]), 32'(m_ctrl[i]));
      chk($sformatf("ex_illegal[%0d]", i),  32'(o_ill[i]),  32'(m_ill[i]));
      chk($sformatf("ex_use_imm[%0d]", i),  32'(o_imm[i]),  32'(m_imm[i]));
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic er, input logic fl);
    bit r [3];
    check_regs();
    id_valid = v; id_op = op; id_funct = fn; ex_ready = er; flush = fl;
    #1;
    for (int i = 0; i < 3; i++) begin
      r[i] = model_ready(i, er);
      chk($sformatf("id_ready[%0d]", i), 32'(o_rdy[i]), 32'(r[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, v && r[i] && !fl, er, fl, op, fn);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
  endtask

  logic [5:0] op_pick [20] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd8, 6'd9, 6'd2, 6'd3,
                               6'd4, 6'd5, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd63, 6'd1};
  logic [5:0] fn_pick [18] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                               6'd43, 6'd0, 6'd2, 6'd3, 6'd24, 6'd25, 6'd26, 6'd27, 6'd1};

  initial begin
    int busy_n, done_n;
    bit seen;
    init_tables();
    model_reset();
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; id_op = '0; id_funct = '0;
    @(negedge clk); @(negedge clk);
    check_regs();
    chk("rst_id_ready", 32'(rdy0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_id_ready", 32'(rdy0), 32'd1);
    @(negedge clk);

    // LW through the default configuration.
    step(1'b1, 6'd35, 6'd0, 1'b1, 1'b0);
    chk("lw_vld", 32'(vld0), 32'd1);
    chk("lw_ctrl", 32'(ctrl0), 32'd1);
    chk("lw_imm", 32'(imm0), 32'd1);
    chk("lw_ill", 32'(ill0), 32'd0);

    // Back-to-back: sub, nor, lui.
    step(1'b1, 6'd0, 6'd34, 1'b1, 1'b0);
    chk("b2b_sub", 32'(ctrl0), 32'd2);
    step(1'b1, 6'd0, 6'd39, 1'b1, 1'b0);
    chk("b2b_nor", 32'(ctrl0), 32'd7);
    step(1'b1, 6'd15, 6'd0, 1'b1, 1'b0);
    chk("b2b_lui", 32'(ctrl0), 32'd14);
    chk("lui_ctrl_w6", 32'(ctrl1), 32'd14);

    // Stall: slt held while ex_ready is low.
    step(1'b1, 6'd0, 6'd42, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 6'd8, 6'd0, 1'b0, 1'b0);
      chk("stall_ctrl", 32'(ctrl0), 32'd5);
      chk("stall_vld", 32'(vld0), 32'd1);
    end
    step(1'b1, 6'd8, 6'd0, 1'b1, 1'b0);
    chk("after_stall_addi", 32'(ctrl0), 32'd1);
    idle(2);

    // MULT occupancy in configuration 0.
    step(1'b1, 6'd0, 6'd24, 1'b1, 1'b0);
    busy_n = 0; done_n = 0; seen = 0;
    for (int k = 0; k < 10; k++) begin
      busy_n += int'(bsy0);
      done_n += int'(dn0);
      if (bsy0) chk("md_no_vld", 32'(vld0), 32'd0);
      if (vld0 && !seen) begin
        seen = 1;
        chk("md_ctrl", 32'(ctrl0), 32'd12);
        chk("md_done_first", 32'(dn0), 32'd1);
      end
      idle(1);
    end
    chk("md_busy_cycles", 32'(busy_n), 32'd4);
    chk("md_done_pulses", 32'(done_n), 32'd1);
    chk("md_result_seen", 32'(seen), 32'd1);

    // Illegal encodings.
    step(1'b1, 6'd63, 6'd0, 1'b1, 1'b0);
    chk("ill_op_ill", 32'(ill0), 32'd1);
    chk("ill_op_ctrl", 32'(ctrl0), 32'd0);
    chk("ill_op_vld", 32'(vld0), 32'd1);
    step(1'b1, 6'd0, 6'd1, 1'b1, 1'b0);
    chk("ill_fn_ill", 32'(ill0), 32'd1);
    step(1'b1, 6'd0, 6'd26, 1'b1, 1'b0);
    chk("nomd_div_ill", 32'(ill2), 32'd1);
    chk("nomd_div_busy", 32'(bsy2), 32'd0);
    chk("nomd_div_vld", 32'(vld2), 32'd1);
    chk("md_div_busy", 32'(bsy0), 32'd1);
    idle(6);

    // Flush in the second MD cycle.
    step(1'b1, 6'd0, 6'd25, 1'b1, 1'b0);
    step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    step(1'b1, 6'd35, 6'd0, 1'b1, 1'b1);
    chk("flush_busy", 32'(bsy0), 32'd0);
    chk("flush_vld", 32'(vld0), 32'd0);
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      done_n += int'(dn0);
      idle(1);
    end
    chk("flush_no_done", 32'(done_n), 32'd0);

    // Asynchronous reset in the middle of a DIV.
    step(1'b1, 6'd0, 6'd26, 1'b1, 1'b0);
    step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    chk("pre_rst_busy", 32'(bsy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bsy0), 32'd0);
    chk("rst_vld", 32'(vld0), 32'd0);
    chk("rst_ctrl", 32'(ctrl0), 32'd0);
    chk("rst_imm_ill", 32'({imm0, ill0, dn0}), 32'd0);
    chk("rst_rdy", 32'(rdy0), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_regs();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) < 8) ? op_pick[$urandom_range(0, 19)] : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 9) < 7) ? fn_pick[$urandom_range(0, 17)] : 6'($urandom_range(0, 63));
      step(1'($urandom_range(0, 9) < 7), op, fn, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) < 4));
    end
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
